// File: rtl/control_fsm_p.sv
// Four-state instruction sequencer for a simple bus-based processor datapath.
// Optional load/store support is enabled by defining CTRL_LDST_EN.
//
// state | meaning
// T0    | idle / fetch: latch ir when run=1
// T1    | first execute step (all opcodes)
// T2    | second execute step (ADD, SUB, LD, ST)
// T3    | third execute step (ADD, SUB, LD)
module control_fsm_p #(
    parameter int REG_BITS = 3
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       run,
    input  logic [3+2*REG_BITS-1:0]    ir,
    input  logic                       g_nz,
    output logic                       ir_in,
    output logic [(2**REG_BITS)-1:0]   r_in,
    output logic [(2**REG_BITS)-1:0]   r_out,
    output logic                       a_in,
    output logic                       g_in,
    output logic                       g_out,
    output logic                       add_sub,
    output logic                       din_out,
    output logic                       addr_in,
    output logic                       dout_in,
    output logic                       w_d,
    output logic                       done
);

    localparam int NREGS = 2**REG_BITS;
    localparam int IR_W  = 3 + 2*REG_BITS;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IR_W-1:0]       instr_q, instr_d;
    logic [2:0]            op;
    logic [2:0]            op_eff;
    logic [REG_BITS-1:0]   fld_x;
    logic [REG_BITS-1:0]   fld_y;

    assign op    = instr_q[IR_W-1 -: 3];
    assign fld_x = instr_q[2*REG_BITS-1 -: REG_BITS];
    assign fld_y = instr_q[REG_BITS-1:0];

`ifdef CTRL_LDST_EN
    assign op_eff = op;
`else
    // Without the memory path, loads and stores collapse to a one-cycle no-op.
    assign op_eff = (op == OP_LD || op == OP_ST) ? OP_NOP : op;
`endif

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= T0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            T0: begin
                if (run) begin
                    instr_d = ir;
                    state_d = T1;
                end
            end
            T1: begin
                case (op_eff)
                    OP_ADD, OP_SUB, OP_LD, OP_ST: state_d = T2;
                    default:                      state_d = T0;
                endcase
            end
            T2: begin
                case (op_eff)
                    OP_ADD, OP_SUB, OP_LD: state_d = T3;
                    default:               state_d = T0;
                endcase
            end
            default: state_d = T0;
        endcase
    end

    always_comb begin
        ir_in   = 1'b0;
        r_in    = '0;
        r_out   = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        add_sub = 1'b0;
        din_out = 1'b0;
        addr_in = 1'b0;
        dout_in = 1'b0;
        w_d     = 1'b0;
        done    = 1'b0;
        if (!resetn) begin
            case (state_q)
                T0: ir_in = run;
                T1: begin
                    case (op_eff)
                        OP_MV: begin
                            r_out[fld_y] = 1'b1;
                            r_in[fld_x]  = 1'b1;
                            done         = 1'b1;
                        end
                        OP_MVI: begin
                            din_out     = 1'b1;
                            r_in[fld_x] = 1'b1;
                            done        = 1'b1;
                        end
                        OP_MVNZ: begin
                            if (g_nz) begin
                                r_out[fld_y] = 1'b1;
                                r_in[fld_x]  = 1'b1;
                            end
                            done = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            r_out[fld_x] = 1'b1;
                            a_in         = 1'b1;
                        end
`ifdef CTRL_LDST_EN
                        OP_LD, OP_ST: begin
                            r_out[fld_y] = 1'b1;
                            addr_in      = 1'b1;
                        end
`endif
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    case (op_eff)
                        OP_ADD, OP_SUB: begin
                            r_out[fld_y] = 1'b1;
                            g_in         = 1'b1;
                            add_sub      = (op_eff == OP_SUB);
                        end
`ifdef CTRL_LDST_EN
                        OP_ST: begin
                            r_out[fld_x] = 1'b1;
                            dout_in      = 1'b1;
                            w_d          = 1'b1;
                            done         = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                T3: begin
                    case (op_eff)
                        OP_ADD, OP_SUB: begin
                            g_out       = 1'b1;
                            r_in[fld_x] = 1'b1;
                            done        = 1'b1;
                        end
`ifdef CTRL_LDST_EN
                        OP_LD: begin
                            din_out     = 1'b1;
                            r_in[fld_x] = 1'b1;
                            done        = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm_p.sv
// Directed bench for control_fsm_p: REG_BITS=3 main instance plus a REG_BITS=4 instance.
// Expectations for LD/ST follow the CTRL_LDST_EN build setting.
module tb_control_fsm_p;

    logic        clock;
    logic        resetn;
    logic        run, run4;
    logic [8:0]  ir;
    logic [12:0] ir4;
    logic        g_nz;

    logic        ir_in, a_in, g_in, g_out, add_sub, din_out, addr_in, dout_in, w_d, done;
    logic [7:0]  r_in, r_out;
    logic        ir_in4, a_in4, g_in4, g_out4, add_sub4, din_out4, addr_in4, dout_in4, w_d4, done4;
    logic [15:0] r_in4, r_out4;

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] C_A_IN  = 9'b1_0000_0000;
    localparam logic [8:0] C_G_IN  = 9'b0_1000_0000;
    localparam logic [8:0] C_G_OUT = 9'b0_0100_0000;
    localparam logic [8:0] C_SUB   = 9'b0_0010_0000;
    localparam logic [8:0] C_DIN   = 9'b0_0001_0000;
    localparam logic [8:0] C_ADDR  = 9'b0_0000_1000;
    localparam logic [8:0] C_DOUT  = 9'b0_0000_0100;
    localparam logic [8:0] C_WD    = 9'b0_0000_0010;
    localparam logic [8:0] C_DONE  = 9'b0_0000_0001;

    control_fsm_p #(.REG_BITS(3)) u_dut (
        .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_nz(g_nz),
        .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in),
        .g_out(g_out), .add_sub(add_sub), .din_out(din_out), .addr_in(addr_in),
        .dout_in(dout_in), .w_d(w_d), .done(done)
    );

    control_fsm_p #(.REG_BITS(4)) u_dut4 (
        .clock(clock), .resetn(resetn), .run(run4), .ir(ir4), .g_nz(g_nz),
        .ir_in(ir_in4), .r_in(r_in4), .r_out(r_out4), .a_in(a_in4), .g_in(g_in4),
        .g_out(g_out4), .add_sub(add_sub4), .din_out(din_out4), .addr_in(addr_in4),
        .dout_in(dout_in4), .w_d(w_d4), .done(done4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive inputs, let them settle, then compare the packed output vector.
    task automatic step(input string tag, input logic r, input logic [8:0] i,
                        input logic exp_ir_in, input logic [7:0] exp_r_in,
                        input logic [7:0] exp_r_out, input logic [8:0] exp_ctl);
        logic [25:0] obs, exp;
        run = r;
        ir  = i;
        #1;
        obs = {ir_in, r_in, r_out, a_in, g_in, g_out, add_sub, din_out,
               addr_in, dout_in, w_d, done};
        exp = {exp_ir_in, exp_r_in, exp_r_out, exp_ctl};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        tick();
    endtask

    initial begin
        logic [40:0] obs4, exp4;
        resetn = 1'b1;
        run    = 1'b0;
        run4   = 1'b0;
        ir     = '0;
        ir4    = '0;
        g_nz   = 1'b0;
        tick();
        step("reset_outputs_zero", 1'b1, 9'b000_010_101, 1'b0, 8'h00, 8'h00, 9'h000);
        resetn = 1'b0;
        step("idle_t0", 1'b0, 9'b000_010_101, 1'b0, 8'h00, 8'h00, 9'h000);

        // MV R2,R5 alongside MV R15,R0 on the wide instance
        run4 = 1'b1;
        ir4  = 13'b000_1111_0000;
        step("mv_fetch", 1'b1, 9'b000_010_101, 1'b1, 8'h00, 8'h00, 9'h000);
        run4 = 1'b0;
        run  = 1'b0;
        #1;
        obs4 = {ir_in4, r_in4, r_out4, a_in4, g_in4, g_out4, add_sub4, din_out4,
                addr_in4, dout_in4, w_d4, done4};
        exp4 = {1'b0, 16'h8000, 16'h0001, C_DONE};
        checks++;
        assert (obs4 === exp4) else begin
            failures++;
            $error("FAIL mv_wide_t1 observed=%h expected=%h", obs4, exp4);
        end
        step("mv_t1", 1'b0, 9'b000_010_101, 1'b0, 8'h04, 8'h20, C_DONE);
        step("mv_back_t0", 1'b0, 9'b000_010_101, 1'b0, 8'h00, 8'h00, 9'h000);

        // SUB R1,R3; ir changes mid-instruction must not matter; then ADD R3,R3 back-to-back
        step("sub_fetch", 1'b1, 9'b011_001_011, 1'b1, 8'h00, 8'h00, 9'h000);
        step("sub_t1", 1'b1, 9'b111_111_111, 1'b0, 8'h00, 8'h02, C_A_IN);
        step("sub_t2", 1'b0, 9'b011_001_011, 1'b0, 8'h00, 8'h08, C_G_IN | C_SUB);
        step("sub_t3", 1'b1, 9'b010_011_011, 1'b0, 8'h02, 8'h00, C_G_OUT | C_DONE);
        step("add_fetch_nogap", 1'b1, 9'b010_011_011, 1'b1, 8'h00, 8'h00, 9'h000);
        step("add_xx_t1", 1'b0, 9'b010_011_011, 1'b0, 8'h00, 8'h08, C_A_IN);
        step("add_xx_t2", 1'b0, 9'b010_011_011, 1'b0, 8'h00, 8'h08, C_G_IN);
        step("add_xx_t3", 1'b0, 9'b010_011_011, 1'b0, 8'h08, 8'h00, C_G_OUT | C_DONE);
        step("add_back_t0", 1'b0, 9'b010_011_011, 1'b0, 8'h00, 8'h00, 9'h000);

        // MVNZ R4,R0 with g_nz low then high
        g_nz = 1'b0;
        step("mvnz0_fetch", 1'b1, 9'b110_100_000, 1'b1, 8'h00, 8'h00, 9'h000);
        step("mvnz0_t1", 1'b1, 9'b110_100_000, 1'b0, 8'h00, 8'h00, C_DONE);
        step("mvnz1_fetch", 1'b1, 9'b110_100_000, 1'b1, 8'h00, 8'h00, 9'h000);
        g_nz = 1'b1;
        step("mvnz1_t1", 1'b0, 9'b110_100_000, 1'b0, 8'h10, 8'h01, C_DONE);
        g_nz = 1'b0;

        // MVI R7
        step("mvi_fetch", 1'b1, 9'b001_111_000, 1'b1, 8'h00, 8'h00, 9'h000);
        step("mvi_t1", 1'b0, 9'b001_111_000, 1'b0, 8'h80, 8'h00, C_DIN | C_DONE);

        // ADD R1,R2 aborted by reset in T2, then rerun to completion
        step("abort_fetch", 1'b1, 9'b010_001_010, 1'b1, 8'h00, 8'h00, 9'h000);
        step("abort_t1", 1'b0, 9'b010_001_010, 1'b0, 8'h00, 8'h02, C_A_IN);
        resetn = 1'b1;
        step("abort_rst_in_t2", 1'b0, 9'b010_001_010, 1'b0, 8'h00, 8'h00, 9'h000);
        resetn = 1'b0;
        step("abort_after_t0", 1'b0, 9'b010_001_010, 1'b0, 8'h00, 8'h00, 9'h000);
        step("rerun_fetch", 1'b1, 9'b010_001_010, 1'b1, 8'h00, 8'h00, 9'h000);
        step("rerun_t1", 1'b0, 9'b010_001_010, 1'b0, 8'h00, 8'h02, C_A_IN);
        step("rerun_t2", 1'b0, 9'b010_001_010, 1'b0, 8'h00, 8'h04, C_G_IN);
        step("rerun_t3", 1'b0, 9'b010_001_010, 1'b0, 8'h02, 8'h00, C_G_OUT | C_DONE);

        // ST R6,R2 and LD R5,R1
        step("st_fetch", 1'b1, 9'b101_110_010, 1'b1, 8'h00, 8'h00, 9'h000);
`ifdef CTRL_LDST_EN
        step("st_t1", 1'b0, 9'b101_110_010, 1'b0, 8'h00, 8'h04, C_ADDR);
        step("st_t2", 1'b0, 9'b101_110_010, 1'b0, 8'h00, 8'h40, C_DOUT | C_WD | C_DONE);
`else
        step("st_t1_nop", 1'b0, 9'b101_110_010, 1'b0, 8'h00, 8'h00, C_DONE);
`endif
        step("st_back_t0", 1'b0, 9'b101_110_010, 1'b0, 8'h00, 8'h00, 9'h000);
        step("ld_fetch", 1'b1, 9'b100_101_001, 1'b1, 8'h00, 8'h00, 9'h000);
`ifdef CTRL_LDST_EN
        step("ld_t1", 1'b0, 9'b100_101_001, 1'b0, 8'h00, 8'h02, C_ADDR);
        step("ld_t2", 1'b0, 9'b100_101_001, 1'b0, 8'h00, 8'h00, 9'h000);
        step("ld_t3", 1'b0, 9'b100_101_001, 1'b0, 8'h20, 8'h00, C_DIN | C_DONE);
`else
        step("ld_t1_nop", 1'b0, 9'b100_101_001, 1'b0, 8'h00, 8'h00, C_DONE);
`endif
        step("ld_back_t0", 1'b0, 9'b100_101_001, 1'b0, 8'h00, 8'h00, 9'h000);

        // NOP
        step("nop_fetch", 1'b1, 9'b111_000_000, 1'b1, 8'h00, 8'h00, 9'h000);
        step("nop_t1", 1'b0, 9'b111_000_000, 1'b0, 8'h00, 8'h00, C_DONE);
        step("nop_back_t0", 1'b0, 9'b111_000_000, 1'b0, 8'h00, 8'h00, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
